sram_like_to_axi: RTL and testbench
===================================

// Module: sram_like_to_axi
// PURPOSE
//  Arbitrates the instruction (read-only) and data (read/write) sram-like ports onto a single AXI3 master.
//  Sits directly downstream of the i-/d-sram-to-sram-like bridges and upstream of the SoC AXI crossbar.
//  One transaction is outstanding at a time, and every transaction is a single beat (no bursts).
// PARAMETERS
//  INST_ID  4'd0  ARID used for instruction fetches
//  DATA_ID  4'd1  ARID/AWID/WID used for data accesses
// PORTS
//  clk        in   1   clock; all state changes on the rising edge
//  resetn     in   1   reset: asynchronous, active-low
//  inst_req   in   1   instruction read request
//  inst_wr    in   1   ignored; inst port is read-only
//  inst_size  in   2   0=byte, 1=half, 2=word
//  inst_addr  in   32  byte address
//  inst_wdata in   32  ignored
//  inst_rdata out  32  read data, valid with inst_data_ok
//  inst_addr_ok / inst_data_ok  out 1   sram-like handshakes
//  data_req / data_wr  in   1   data request; 1 = write
//  data_size  in   2   as inst_size
//  data_addr / data_wdata  in   32  byte address / write data (lane-aligned)
//  data_rdata out  32  read data, valid with data_data_ok
//  data_addr_ok / data_data_ok  out 1   sram-like handshakes
//  AR channel: arid[4] araddr[32] arlen[8] arsize[3] arburst[2] arlock[2] arcache[4] arprot[3] arvalid out; arready in
//  R channel:  rid[4] rdata[32] rresp[2] rlast rvalid in; rready out
//  AW channel: awid..awprot (same widths as AR), awvalid out; awready in
//  W channel:  wid[4] wdata[32] wstrb[4] wlast wvalid out; wready in
//  B channel:  bid[4] bresp[2] bvalid in; bready out
// BEHAVIOUR
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP. Reset state is IDLE.
//  Reset values: all valid/ready/addr_ok/data_ok outputs 0; latched address, data, size and strobe registers 0.
//  IDLE: addr_ok is combinational with req and is high for exactly one requester.
//    Data wins over instruction when both request in the same cycle; the instruction request waits.
//    On accept, latch addr/size/wdata/wstrb/id.
//    Next state: data_wr ? WR_ADDR : RD_ADDR.
//  RD_ADDR: arvalid=1 and is held stable until arready; then go to RD_DATA.
//  RD_DATA: rready=1. On rvalid, pulse the owner's data_ok for one cycle with *_rdata=rdata (combinational); go to IDLE.
//  WR_ADDR: awvalid and wvalid are raised together. Each drops independently on its own ready (flags aw_done, w_done).
//    Go to WR_RESP when both are done, including both in the same cycle.
//  WR_RESP: bready=1. On bvalid, pulse data_data_ok for one cycle; go to IDLE.
//  addr_ok is never raised outside IDLE, so a new request can be accepted no earlier than the cycle after data_ok.
//  Fixed fields: arlen/awlen=0, burst=2'b01, lock=0, cache=0, prot=0, wlast=1.
//    arsize/awsize={1'b0,size}; address passed through unaligned.
//  wstrb: size0 -> 4'b0001<<addr[1:0]; size1 -> addr[1]?4'b1100:4'b0011; size2/3 -> 4'b1111.
//  rresp/bresp are ignored (no bus-error path). rid/bid are not checked, because only one transaction is outstanding.
//  Latched fields never change while the FSM is not IDLE, regardless of upstream req/addr changes.
//    Upstream flush does not abort an accepted transaction; it always completes to data_ok.
//  Reset mid-transaction: return to IDLE immediately and drop all valids. The AXI slave is reset by the same signal.
// STRUCTURE
//  Shared package/header: state encodings, AXI constants (BURST_INCR, LEN_SINGLE), size encodings.
//  One natural sub-module: axi_wstrb_gen (size, addr[1:0] -> wstrb); everything else is a single FSM.
// TESTING
//  Inst read 0xBFC00000 size2; arready after 2 cycles, rdata=0x3C1D0000 -> arid=0, arsize=2, inst_data_ok=1 for one cycle with that data.
//  data_req and inst_req together -> data_addr_ok=1, inst_addr_ok=0; inst is accepted in the first IDLE cycle after data_data_ok.
//  Byte write addr 0x80000003, wdata=0xAB000000 -> wstrb=4'b1000, awsize=0, wlast=1; data_data_ok only after bvalid.
//  Write with wready 3 cycles before awready, then again with both ready in the same cycle -> exactly one AW and one W beat; FSM reaches WR_RESP.
//  Change data_addr while in RD_DATA -> araddr and the latched size stay unchanged; no second addr_ok.
//  Assert resetn=0 during RD_ADDR -> arvalid=0 asynchronously; after release, FSM is IDLE and all handshake outputs are 0.

Source files
------------

// File: rtl/sram_like_to_axi_pkg.sv
// sram_like_to_axi_pkg: shared states, AXI constants and size encodings for the sram-like to AXI3 bridge
package sram_like_to_axi_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [7:0] LEN_SINGLE  = 8'd0;
  localparam logic [1:0] SIZE_BYTE   = 2'd0;
  localparam logic [1:0] SIZE_HALF   = 2'd1;
  localparam logic [1:0] SIZE_WORD   = 2'd2;
  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction
endpackage

// File: rtl/sram_like_to_axi_if.sv
// sram_like_to_axi_if: sram-like request port and single-beat AXI3 master bus bundles
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;
  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

interface sram_like_to_axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/sram_like_to_axi_wstrb.sv
// axi_wstrb_gen: byte-lane write strobe from access size and low address bits
module axi_wstrb_gen
  import sram_like_to_axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic [3:0] wstrb
);
  // word (and the unused size 3) enables every lane; half picks the upper or lower pair
  always_comb
    wstrb = size >= SIZE_WORD ? 4'b1111 :
            size == SIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
            4'b0001 << addr;
endmodule

// File: rtl/sram_like_to_axi.sv
// sram_like_to_axi: arbitrates inst/data sram-like ports onto one single-beat, single-outstanding AXI3 master
module sram_like_to_axi
  import sram_like_to_axi_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  sram_like_if.slave                inst,
  sram_like_if.slave                data,
  sram_like_to_axi_if.master        axi
);
  state_t      state, state_nxt;
  logic        own_data;
  logic        aw_done, w_done;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q, wstrb_nxt;
  logic        accept, sel_data;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic        unused_ok;

  assign sel_data = data.req;
  assign accept   = state == IDLE && (inst.req || data.req);
  assign sel_size = sel_data ? data.size : inst.size;
  assign sel_addr = sel_data ? data.addr : inst.addr;

  axi_wstrb_gen u_wstrb (.size(sel_size), .addr(sel_addr[1:0]), .wstrb(wstrb_nxt));

  // state register; reset drops straight back to IDLE so every valid falls immediately
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;

  // capture the winning request once; the fields stay frozen until the next IDLE accept
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      own_data <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (accept) begin
      own_data <= sel_data;
      addr_q   <= sel_addr;
      size_q   <= sel_size;
      wdata_q  <= sel_data ? data.wdata : '0;
      wstrb_q  <= wstrb_nxt;
    end

  // AW and W complete independently; each flag remembers its own handshake
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != WR_ADDR) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= aw_done | axi.awready;
      w_done  <= w_done | axi.wready;
    end

  // next state and handshakes; addr_ok only in IDLE, data wins over instruction
  always_comb begin
    state_nxt     = state;
    axi.arvalid   = 1'b0;
    axi.rready    = 1'b0;
    axi.awvalid   = 1'b0;
    axi.wvalid    = 1'b0;
    axi.bready    = 1'b0;
    inst.addr_ok  = 1'b0;
    data.addr_ok  = 1'b0;
    inst.data_ok  = 1'b0;
    data.data_ok  = 1'b0;
    case (state)
      IDLE: begin
        inst.addr_ok = inst.req && !data.req;
        data.addr_ok = data.req;
        if (accept) state_nxt = sel_data && data.wr ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        axi.rready   = 1'b1;
        inst.data_ok = axi.rvalid && !own_data;
        data.data_ok = axi.rvalid && own_data;
        if (axi.rvalid) state_nxt = IDLE;
      end
      WR_ADDR: begin
        axi.awvalid = !aw_done;
        axi.wvalid  = !w_done;
        if ((aw_done || axi.awready) && (w_done || axi.wready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        axi.bready   = 1'b1;
        data.data_ok = axi.bvalid;
        if (axi.bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign inst.rdata  = axi.rdata;
  assign data.rdata  = axi.rdata;

  assign axi.arid    = own_data ? DATA_ID : INST_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = LEN_SINGLE;
  assign axi.arsize  = axi_size(size_q);
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = LEN_SINGLE;
  assign axi.awsize  = axi_size(size_q);
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;

  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;

  // inst writes, response codes and ids carry no information for a single-outstanding bridge
  assign unused_ok = ^{inst.wr, inst.wdata, axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_sram_like_to_axi.sv
// tb_sram_like_to_axi: scoreboard bench for the sram-like to AXI3 bridge
module tb_sram_like_to_axi;
  typedef struct {logic [31:0] addr; logic [3:0] id; logic [2:0] size;} ax_t;
  typedef struct {logic [31:0] data; logic [3:0] strb;} w_t;
  typedef struct {logic is_data; logic is_wr; logic [31:0] rdata;} resp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_like_if        inst_if ();
  sram_like_if        data_if ();
  sram_like_to_axi_if axi ();

  sram_like_to_axi dut (.clk(clk), .resetn(resetn), .inst(inst_if), .data(data_if), .axi(axi));

  ax_t         exp_ar[$];
  ax_t         exp_aw[$];
  w_t          exp_w[$];
  resp_t       exp_resp[$];
  logic [31:0] rd_q[$];
  int checks = 0, passes = 0;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int cyc = 0, last_dok_cyc = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [3:0] id, input logic [2:0] s);
    ax_t t;
    t.addr = a; t.id = id; t.size = s;
    exp_ar.push_back(t);
  endtask

  task automatic push_resp(input logic is_data, input logic is_wr, input logic [31:0] d);
    resp_t t;
    t.is_data = is_data; t.is_wr = is_wr; t.rdata = d;
    exp_resp.push_back(t);
  endtask

  task automatic push_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                            input logic [3:0] strb);
    ax_t t;
    w_t  w;
    t.addr = a; t.id = 4'd1; t.size = {1'b0, s};
    w.data = d; w.strb = strb;
    exp_aw.push_back(t);
    exp_w.push_back(w);
    push_resp(1'b1, 1'b1, 32'h0);
  endtask

  initial forever @(posedge clk) cyc++;

  // read slave: arready after ar_wait cycles, rvalid r_wait cycles after the AR beat
  initial begin
    int n;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rid = 0; axi.rresp = 0; axi.rlast = 0;
    forever begin
      @(posedge clk); #1;
      if (!axi.arvalid) continue;
      n = 0;
      while (n < ar_wait && axi.arvalid) begin @(posedge clk); #1; n++; end
      if (!axi.arvalid) continue;
      axi.arready = 1;
      @(posedge clk); #1;
      axi.arready = 0;
      n = 0;
      while (n < r_wait) begin @(posedge clk); #1; n++; end
      axi.rvalid = 1; axi.rlast = 1;
      axi.rdata = rd_q.size() != 0 ? rd_q.pop_front() : 32'hDEADBEEF;
      @(posedge clk); #1;
      axi.rvalid = 0; axi.rlast = 0;
    end
  end

  initial begin
    int n;
    axi.awready = 0;
    forever begin
      @(posedge clk); #1;
      if (!axi.awvalid) continue;
      n = 0;
      while (n < aw_wait && axi.awvalid) begin @(posedge clk); #1; n++; end
      if (!axi.awvalid) continue;
      axi.awready = 1;
      @(posedge clk); #1;
      axi.awready = 0;
    end
  end

  initial begin
    int n;
    axi.wready = 0;
    forever begin
      @(posedge clk); #1;
      if (!axi.wvalid) continue;
      n = 0;
      while (n < w_wait && axi.wvalid) begin @(posedge clk); #1; n++; end
      if (!axi.wvalid) continue;
      axi.wready = 1;
      @(posedge clk); #1;
      axi.wready = 0;
    end
  end

  initial begin
    int n;
    axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
    forever begin
      @(posedge clk); #1;
      if (!axi.bready) continue;
      n = 0;
      while (n < b_wait && axi.bready) begin @(posedge clk); #1; n++; end
      if (!axi.bready) continue;
      axi.bvalid = 1; axi.bid = 4'd1;
      @(posedge clk); #1;
      axi.bvalid = 0;
    end
  end

  // monitor: every beat and every data_ok pops the scoreboard
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      if (axi.arvalid && axi.arready) begin
        ar_cnt++;
        if (exp_ar.size() == 0) chk("ar_unexpected", axi.araddr, 32'h0);
        else begin
          ax_t e;
          e = exp_ar.pop_front();
          chk("araddr", axi.araddr, e.addr);
          chk("arid", axi.arid, e.id);
          chk("arsize", axi.arsize, e.size);
          chk("arlen_burst", {axi.arlen, axi.arburst}, {8'd0, 2'b01});
        end
      end
      if (axi.awvalid && axi.awready) begin
        aw_cnt++;
        if (exp_aw.size() == 0) chk("aw_unexpected", axi.awaddr, 32'h0);
        else begin
          ax_t e;
          e = exp_aw.pop_front();
          chk("awaddr", axi.awaddr, e.addr);
          chk("awid", axi.awid, e.id);
          chk("awsize", axi.awsize, e.size);
        end
      end
      if (axi.wvalid && axi.wready) begin
        w_cnt++;
        if (exp_w.size() == 0) chk("w_unexpected", axi.wdata, 32'h0);
        else begin
          w_t e;
          e = exp_w.pop_front();
          chk("wdata", axi.wdata, e.data);
          chk("wstrb", axi.wstrb, e.strb);
          chk("wlast_wid", {axi.wlast, axi.wid}, {1'b1, 4'd1});
        end
      end
      if (axi.bvalid && axi.bready) b_cnt++;
      if (inst_if.data_ok || data_if.data_ok) begin
        if (exp_resp.size() == 0) chk("data_ok_unexpected", {inst_if.data_ok, data_if.data_ok}, 2'b00);
        else begin
          resp_t e;
          e = exp_resp.pop_front();
          chk("data_ok_owner", {inst_if.data_ok, data_if.data_ok}, e.is_data ? 2'b01 : 2'b10);
          if (e.is_wr) chk("data_ok_needs_bvalid", axi.bvalid, 1'b1);
          else chk("rdata", e.is_data ? data_if.rdata : inst_if.rdata, e.rdata);
        end
        last_dok_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic is_data, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(posedge clk); #1;
    if (is_data) begin
      data_if.req = 1; data_if.wr = wr; data_if.size = size; data_if.addr = addr; data_if.wdata = wdata;
    end else begin
      inst_if.req = 1; inst_if.wr = 0; inst_if.size = size; inst_if.addr = addr; inst_if.wdata = 0;
    end
    n = 0;
    @(negedge clk);
    while (!(is_data ? data_if.addr_ok : inst_if.addr_ok) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("addr_ok_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    data_if.req = 0;
    inst_if.req = 0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_resp.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk({name, "_complete"}, 32'(exp_resp.size()), 32'd0);
  endtask

  logic [31:0] wv_addr [5] = '{32'h80000003, 32'h80000022, 32'h80000040, 32'h80000001, 32'h80000010};
  logic [1:0]  wv_size [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
  logic [31:0] wv_data [5] = '{32'hAB000000, 32'hCDEF0000, 32'h12345678, 32'h0000CD00, 32'h0000BEEF};
  logic [3:0]  wv_strb [5] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010, 4'b0011};
  int          wv_aww  [5] = '{0, 3, 0, 1, 0};
  int          wv_ww   [5] = '{0, 0, 0, 2, 0};

  initial begin
    int n, ok_seen, aw0, w0, b0;
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0; data_if.wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    chk("rst_sram_hs", {inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok}, 4'b0);
    chk("rst_latched", axi.araddr | axi.wdata, 32'h0);
    chk("rst_size_strb", {axi.arsize, axi.wstrb}, 7'b0);
    @(posedge clk); #1;
    resetn = 1;

    ar_wait = 2; r_wait = 0;
    rd_q.push_back(32'h3C1D0000);
    push_ar(32'hBFC00000, 4'd0, 3'd2);
    push_resp(1'b0, 1'b0, 32'h3C1D0000);
    issue(1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0);
    wait_done("inst_read");

    ar_wait = 0;
    rd_q.push_back(32'h11223344);
    rd_q.push_back(32'h55667788);
    push_ar(32'h80000010, 4'd1, 3'd2);
    push_ar(32'hBFC00004, 4'd0, 3'd2);
    push_resp(1'b1, 1'b0, 32'h11223344);
    push_resp(1'b0, 1'b0, 32'h55667788);
    @(posedge clk); #1;
    data_if.req = 1; data_if.wr = 0; data_if.size = 2; data_if.addr = 32'h80000010;
    inst_if.req = 1; inst_if.size = 2; inst_if.addr = 32'hBFC00004;
    @(negedge clk);
    chk("arb_addr_ok", {data_if.addr_ok, inst_if.addr_ok}, 2'b10);
    @(posedge clk); #1;
    data_if.req = 0;
    n = 0;
    @(negedge clk);
    while (!inst_if.addr_ok && n < 50) begin @(negedge clk); n++; end
    chk("inst_accept_cycle", 32'(cyc), 32'(last_dok_cyc + 1));
    @(posedge clk); #1;
    inst_if.req = 0;
    wait_done("arb");

    b_wait = 2;
    for (int i = 0; i < 5; i++) begin
      aw_wait = wv_aww[i]; w_wait = wv_ww[i];
      aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
      push_write(wv_addr[i], wv_size[i], wv_data[i], wv_strb[i]);
      issue(1'b1, 1'b1, wv_size[i], wv_addr[i], wv_data[i]);
      wait_done("write");
      repeat (2) @(negedge clk);
      chk("write_beats", {8'(aw_cnt - aw0), 8'(w_cnt - w0), 8'(b_cnt - b0)}, 24'h010101);
    end

    ar_wait = 0; r_wait = 4;
    rd_q.push_back(32'hA5A55A5A);
    push_ar(32'h80001002, 4'd1, 3'd1);
    push_resp(1'b1, 1'b0, 32'hA5A55A5A);
    @(posedge clk); #1;
    data_if.req = 1; data_if.wr = 0; data_if.size = 1; data_if.addr = 32'h80001002;
    @(negedge clk);
    chk("hold_first_addr_ok", data_if.addr_ok, 1'b1);
    @(posedge clk); #1;
    data_if.addr = 32'h12345678; data_if.size = 0;
    n = 0; ok_seen = 0;
    @(negedge clk);
    while (!data_if.data_ok && n < 50) begin
      if (data_if.addr_ok) ok_seen++;
      @(negedge clk);
      n++;
    end
    chk("hold_araddr", axi.araddr, 32'h80001002);
    chk("hold_arsize", axi.arsize, 3'd1);
    chk("hold_no_second_addr_ok", 32'(ok_seen), 32'd0);
    @(posedge clk); #1;
    data_if.req = 0;
    wait_done("hold");

    ar_wait = 20; r_wait = 0;
    issue(1'b0, 1'b0, 2'd2, 32'hBFC00100, 32'h0);
    n = 0;
    @(negedge clk);
    while (!axi.arvalid && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_arvalid_seen", axi.arvalid, 1'b1);
    #2;
    resetn = 0;
    #1;
    chk("rst_async_arvalid", axi.arvalid, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    chk("post_rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    chk("post_rst_sram_hs", {inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok}, 4'b0);
    chk("post_rst_araddr", axi.araddr, 32'h0);

    ar_wait = 0;
    rd_q.delete();
    rd_q.push_back(32'h0BADF00D);
    push_ar(32'hBFC00010, 4'd0, 3'd2);
    push_resp(1'b0, 1'b0, 32'h0BADF00D);
    issue(1'b0, 1'b0, 2'd2, 32'hBFC00010, 32'h0);
    wait_done("recover");

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_resp.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
